// File: rtl/sr_latch_driver_if.sv
// Command handshake between a requester and the SR latch driver.
interface sr_latch_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_op, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, output cmd_ready);
endinterface

// File: rtl/sr_latch_driver.sv
// Sequences set/reset/toggle/check operations onto a gated SR latch and
// verifies the latch output once the operation has settled.
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned SETTLE  = 1
) (
    input  logic                clk,
    input  logic                rst,
    sr_latch_driver_if.slave    cmd,
    output logic                s,
    output logic                r,
    output logic                e,
    input  logic                q_in,
    output logic                done,
    output logic                err,
    output logic                q_exp,
    output logic [7:0]          err_cnt
);

    localparam int unsigned ERR_W   = 8;
    localparam int unsigned CNT_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] OP_CHECK  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_SETTLE,
        ST_CHECK
    } state_e;

    // Settle phase disappears entirely when SETTLE is zero.
    localparam state_e POST_HOLD = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               q_exp_q, q_exp_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               e_q, e_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               drive_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            q_exp_q     <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            e_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_exp_q     <= q_exp_d;
            s_q         <= s_d;
            r_q         <= r_d;
            e_q         <= e_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_exp_d   = q_exp_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid && cmd_ready_q) begin
                    cnt_d = '0;
                    case (cmd.cmd_op)
                        OP_SET:    q_exp_d = 1'b1;
                        OP_RESET:  q_exp_d = 1'b0;
                        OP_TOGGLE: q_exp_d = ~q_in;
                        default:   q_exp_d = q_in;
                    endcase
                    state_d = (cmd.cmd_op == OP_CHECK) ? POST_HOLD : ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == CNT_W'(PULSE_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                cnt_d   = '0;
                state_d = POST_HOLD;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        // The target value picks the latch input, so s and r are mutually exclusive.
        drive_c     = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        s_d         = drive_c &&  q_exp_d;
        r_d         = drive_c && !q_exp_d;
        e_d         = (state_d == ST_PULSE);
        done_d      = (state_d == ST_CHECK);
        err_d       = done_d && (q_in != q_exp_d);
        cmd_ready_d = (state_d == ST_IDLE);
        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign s             = s_q;
    assign r             = r_q;
    assign e             = e_q;
    assign done          = done_q;
    assign err           = err_q;
    assign q_exp         = q_exp_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench: the driver drives a behavioural gated SR latch whose q is
// fed back; expected completions are queued at accept and checked on done.
module tb_sr_latch_driver;

    localparam logic [1:0] OP_CHECK  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default build: PULSE_W=2, SETTLE=1
    sr_latch_driver_if cif ();
    logic s, r, e, done, err, q_exp, lq, lq_clr, fault;
    logic [7:0] err_cnt;

    sr_latch_driver #(.PULSE_W(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .cmd(cif.slave),
        .s(s), .r(r), .e(e), .q_in(lq),
        .done(done), .err(err), .q_exp(q_exp), .err_cnt(err_cnt)
    );

    always_latch begin
        if (lq_clr || fault) lq <= 1'b0;
        else if (e && s)     lq <= 1'b1;
        else if (e && r)     lq <= 1'b0;
    end

    // Short build: PULSE_W=1, SETTLE=0
    sr_latch_driver_if cif2 ();
    logic s2, r2, e2, done2, err2, q_exp2, lq2;
    logic [7:0] err_cnt2;

    sr_latch_driver #(.PULSE_W(1), .SETTLE(0)) dut2 (
        .clk(clk), .rst(rst), .cmd(cif2.slave),
        .s(s2), .r(r2), .e(e2), .q_in(lq2),
        .done(done2), .err(err2), .q_exp(q_exp2), .err_cnt(err_cnt2)
    );

    always_latch begin
        if (lq_clr)          lq2 <= 1'b0;
        else if (e2 && s2)   lq2 <= 1'b1;
        else if (e2 && r2)   lq2 <= 1'b0;
    end

    typedef struct {
        int         cyc;
        logic       q;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_cnt = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // Scoreboard monitor for the default build.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("done_cycle", cyc, x.cyc);
                chk("err",        err, x.err);
                chk("q_exp",      q_exp, x.q);
                chk("err_cnt",    err_cnt, x.cnt);
            end
        end
    end

    // Latch-interface invariants on both builds.
    logic ps, pr, ps2, pr2;
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_and_r",       s & r, 1'b0);
            chk("s_and_r_2",     s2 & r2, 1'b0);
            chk("sr_stable_e",   e  && ((s  != ps)  || (r  != pr)),  1'b0);
            chk("sr_stable_e_2", e2 && ((s2 != ps2) || (r2 != pr2)), 1'b0);
        end
        ps = s; pr = r; ps2 = s2; pr2 = r2;
    end

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic issue(input logic [1:0] op, input bit fault_exp, input bit keep,
                         input bit push, output int t_acc);
        int   n;
        int   lat;
        logic eq;
        exp_t x;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        n = 0;
        while (cif.cmd_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("accept_timeout");
        t_acc = cyc;
        case (op)
            OP_SET:    eq = 1'b1;
            OP_RESET:  eq = 1'b0;
            OP_TOGGLE: eq = ~lq;
            default:   eq = lq;
        endcase
        lat = (op == OP_CHECK) ? 2 : 6;
        if (fault_exp && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
        if (push) begin
            x.cyc = t_acc + lat; x.q = eq; x.err = fault_exp; x.cnt = exp_cnt;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        if (!keep) cif.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(output bit act);
        int n = 0;
        act = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            act = act | s | r | e;
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("done_timeout");
    endtask

    task automatic run2(input logic [1:0] op, input int lat, input logic eq);
        int n = 0;
        int t;
        cif2.cmd_valid = 1'b1;
        cif2.cmd_op    = op;
        while (cif2.cmd_ready !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        if (n >= 30) fail_now("accept2_timeout");
        t = cyc;
        @(posedge clk);
        #1 cif2.cmd_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (done2 !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        if (n >= 30) fail_now("done2_timeout");
        chk("short_latency", cyc - t, lat);
        chk("short_err",     err2, 1'b0);
        chk("short_q_exp",   q_exp2, eq);
        @(negedge clk);
    endtask

    initial begin
        int t, t0, t1, t2;
        bit act;
        cif.cmd_valid  = 1'b0;
        cif.cmd_op     = OP_CHECK;
        cif2.cmd_valid = 1'b0;
        cif2.cmd_op    = OP_CHECK;
        lq_clr = 1'b1;
        fault  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready",   cif.cmd_ready, 1'b0);
        chk("rst_sre",     {s, r, e}, 3'b000);
        chk("rst_done",    {done, err, q_exp}, 3'b000);
        chk("rst_err_cnt", err_cnt, 8'd0);
        rst    = 1'b0;
        lq_clr = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cif.cmd_ready, 1'b1);

        // SET waveform: s over T+1..T+4, e over T+2..T+3
        issue(OP_SET, 1'b0, 1'b0, 1'b1, t);
        for (int i = 1; i <= 6; i++) begin
            chk("set_s", s, (i <= 4) ? 1'b1 : 1'b0);
            chk("set_e", e, (i == 2 || i == 3) ? 1'b1 : 1'b0);
            chk("set_r", r, 1'b0);
            if (i < 6) @(negedge clk);
        end
        chk("set_latch_q", lq, 1'b1);
        chk("set_q_exp",   q_exp, 1'b1);

        // Back-to-back SET, RESET, TOGGLE with valid held
        @(negedge clk);
        issue(OP_SET,    1'b0, 1'b1, 1'b1, t0);
        issue(OP_RESET,  1'b0, 1'b1, 1'b1, t1);
        issue(OP_TOGGLE, 1'b0, 1'b0, 1'b1, t2);
        chk("b2b_spacing_1", t1 - t0, 7);
        chk("b2b_spacing_2", t2 - t1, 7);
        wait_done(act);
        chk("b2b_latch_q", lq, 1'b1);
        chk("b2b_q_exp",   q_exp, 1'b1);

        // CHECK with q=1: no latch activity
        @(negedge clk);
        issue(OP_CHECK, 1'b0, 1'b0, 1'b1, t);
        wait_done(act);
        chk("check_sre_quiet", act, 1'b0);

        // Latch stuck at 0 during SET; repeated until the counter saturates
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            fault = 1'b1;
            issue(OP_SET, 1'b1, 1'b0, 1'b1, t);
            wait_done(act);
            fault = 1'b0;
            if (k == 0) chk("fault_first_cnt", err_cnt, 8'd1);
        end
        @(negedge clk);
        chk("err_cnt_saturated", err_cnt, 8'd255);

        // Reset mid-SET at T+3
        issue(OP_SET, 1'b0, 1'b0, 1'b0, t);
        @(negedge clk);
        @(negedge clk);
        chk("abort_phase", cyc - t, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sre",     {s, e, r}, 3'b000);
        chk("abort_done",    done, 1'b0);
        chk("abort_err_cnt", err_cnt, 8'd0);
        chk("abort_ready",   cif.cmd_ready, 1'b0);
        chk("abort_q_exp",   q_exp, 1'b0);
        exp_cnt = 8'd0;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_back", cif.cmd_ready, 1'b1);
        repeat (6) @(negedge clk);

        // Random traffic under the invariant monitors
        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1, t);
            wait_done(act);
            @(negedge clk);
        end
        begin
            int n = 0;
            while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) fail_now("scoreboard_drain");
        end

        // Short build latencies
        run2(OP_SET,    4, 1'b1);
        run2(OP_CHECK,  1, 1'b1);
        run2(OP_RESET,  4, 1'b0);
        run2(OP_TOGGLE, 4, 1'b1);
        chk("short_latch_q", lq2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
